// File: rtl/cam_frame_capture_if.sv
// Signal bundle between the camera capture stage and its surroundings:
// camera bus and start in, buffer write port and status out.
interface cam_frame_capture_if;
    logic        start;
    logic        cam_pclk;
    logic        cam_vsync;
    logic        cam_href;
    logic [7:0]  cam_data;
    logic [14:0] wr_addr;
    logic [7:0]  wr_data;
    logic        wr_en;
    logic        busy;
    logic        done;
    logic        short_frame;

    modport master (
        input  start, cam_pclk, cam_vsync, cam_href, cam_data,
        output wr_addr, wr_data, wr_en, busy, done, short_frame
    );

    modport slave (
        output start, cam_pclk, cam_vsync, cam_href, cam_data,
        input  wr_addr, wr_data, wr_en, busy, done, short_frame
    );
endinterface

// File: rtl/cam_frame_capture.sv
// Camera capture stage: synchronizes the parallel camera bus, decimates it
// horizontally/vertically and writes one IMG_W x IMG_H frame into the buffer.
module cam_frame_capture #(
    parameter int IMG_W = 160,
    parameter int IMG_H = 120,
    parameter int DEC_X = 4,
    parameter int DEC_Y = 4
) (
    input  logic                clk,
    input  logic                rst,
    cam_frame_capture_if.master bus
);
    localparam int XW  = $clog2(IMG_W + 1);
    localparam int YW  = $clog2(IMG_H + 1);
    localparam int SXW = (DEC_X > 1) ? $clog2(DEC_X) : 1;
    localparam int SYW = (DEC_Y > 1) ? $clog2(DEC_Y) : 1;
    localparam logic [XW-1:0]  X_MAX     = XW'(IMG_W);
    localparam logic [YW-1:0]  Y_MAX     = YW'(IMG_H);
    localparam logic [SXW-1:0] SX_LAST   = SXW'(DEC_X - 1);
    localparam logic [SYW-1:0] SY_LAST   = SYW'(DEC_Y - 1);
    localparam logic [14:0]    ADDR_LAST = 15'(IMG_W * IMG_H - 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT_VS_HI, S_WAIT_VS_LO, S_CAPTURE} state_e;

    // [0],[1] form the 2-flop synchronizer, [2] is the previous synced sample
    logic [2:0] pclk_q, vs_q, href_q;
    logic [7:0] data_s1_q, data_s2_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            pclk_q <= '0;
            vs_q   <= '0;
            href_q <= '0;
        end else begin
            pclk_q <= {pclk_q[1:0], bus.cam_pclk};
            vs_q   <= {vs_q[1:0], bus.cam_vsync};
            href_q <= {href_q[1:0], bus.cam_href};
        end
    end

    always_ff @(posedge clk) begin
        data_s1_q <= bus.cam_data;
        data_s2_q <= data_s1_q;
    end

    logic pix_evt, href, href_fall, vs, vs_rise;
    assign pix_evt   = pclk_q[1] & ~pclk_q[2];
    assign href      = href_q[1];
    assign href_fall = ~href_q[1] & href_q[2];
    assign vs        = vs_q[1];
    assign vs_rise   = vs_q[1] & ~vs_q[2];

    state_e         state_q, state_d;
    logic [XW-1:0]  x_cnt_q, x_cnt_d;
    logic [YW-1:0]  y_cnt_q, y_cnt_d;
    logic [SXW-1:0] sx_q, sx_d;
    logic [SYW-1:0] sy_q, sy_d;
    logic [14:0]    addr_q, addr_d, wr_addr_q, wr_addr_d;
    logic [7:0]     wr_data_q, wr_data_d;
    logic           wr_en_q, wr_en_d, done_q, done_d, short_q, short_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            x_cnt_q   <= '0;
            y_cnt_q   <= '0;
            sx_q      <= '0;
            sy_q      <= '0;
            addr_q    <= '0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            wr_en_q   <= 1'b0;
            done_q    <= 1'b0;
            short_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            x_cnt_q   <= x_cnt_d;
            y_cnt_q   <= y_cnt_d;
            sx_q      <= sx_d;
            sy_q      <= sy_d;
            addr_q    <= addr_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            wr_en_q   <= wr_en_d;
            done_q    <= done_d;
            short_q   <= short_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        x_cnt_d   = x_cnt_q;
        y_cnt_d   = y_cnt_q;
        sx_d      = sx_q;
        sy_d      = sy_q;
        addr_d    = addr_q;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        wr_en_d   = 1'b0;
        done_d    = 1'b0;
        short_d   = short_q;
        unique case (state_q)
            S_IDLE: begin
                // done_q high means the frame just ended; a start in that cycle is dropped
                if (bus.start && !done_q) begin
                    state_d = S_WAIT_VS_HI;
                    short_d = 1'b0;
                    x_cnt_d = '0;
                    y_cnt_d = '0;
                    sx_d    = '0;
                    sy_d    = '0;
                    addr_d  = '0;
                end
            end
            S_WAIT_VS_HI: begin
                if (vs) state_d = S_WAIT_VS_LO;
            end
            S_WAIT_VS_LO: begin
                if (!vs) begin
                    state_d = S_CAPTURE;
                    x_cnt_d = '0;
                    y_cnt_d = '0;
                    sx_d    = '0;
                    sy_d    = '0;
                    addr_d  = '0;
                end
            end
            S_CAPTURE: begin
                if (pix_evt && href) begin
                    if (sy_q == '0 && sx_q == '0 && x_cnt_q < X_MAX) begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = addr_q;
                        wr_data_d = data_s2_q;
                        x_cnt_d   = x_cnt_q + 1'b1;
                        // addr stops at the last location so it can never wrap
                        if (addr_q == ADDR_LAST) begin
                            done_d  = 1'b1;
                            state_d = S_IDLE;
                        end else begin
                            addr_d = addr_q + 15'd1;
                        end
                    end
                    sx_d = (sx_q == SX_LAST) ? '0 : sx_q + 1'b1;
                end
                if (href_fall) begin
                    sx_d    = '0;
                    x_cnt_d = '0;
                    sy_d    = (sy_q == SY_LAST) ? '0 : sy_q + 1'b1;
                    if (sy_q == '0 && y_cnt_q < Y_MAX) y_cnt_d = y_cnt_q + 1'b1;
                end
                if (vs_rise && state_d == S_CAPTURE) begin
                    done_d  = 1'b1;
                    short_d = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.wr_addr     = wr_addr_q;
    assign bus.wr_data     = wr_data_q;
    assign bus.wr_en       = wr_en_q;
    assign bus.done        = done_q;
    assign bus.short_frame = short_q;
    assign bus.busy        = (state_q != S_IDLE) || done_q;
endmodule

// File: tb/tb_cam_frame_capture.sv
// Directed-sequence bench for cam_frame_capture with random camera frames and
// a reference that maps each buffer address back to its source pixel.
module tb_cam_frame_capture;
    localparam int IMG_W = 8;
    localparam int IMG_H = 6;
    localparam int DEC_X = 2;
    localparam int DEC_Y = 2;
    localparam int NPIX  = IMG_W * IMG_H;
    localparam int LAST  = NPIX - 1;

    logic clk;
    logic rst;
    cam_frame_capture_if bus();

    cam_frame_capture #(.IMG_W(IMG_W), .IMG_H(IMG_H), .DEC_X(DEC_X), .DEC_Y(DEC_Y)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: observed no finish, required finish before 90000 cycles");
        $fatal(1, "watchdog");
    end

    logic [7:0]  src [32][32];
    logic [22:0] wq[$];
    int          done_cnt  = 0;
    int          done_last = 0;
    int          wide_cnt  = 0;
    logic        wr_prev   = 1'b0;
    int          n_chk     = 0;
    int          n_pass    = 0;
    int          n_fail    = 0;

    // Record every buffer write and done pulse, sampled away from the active edge
    always @(negedge clk) begin
        if (bus.wr_en === 1'b1) begin
            wq.push_back({bus.wr_addr, bus.wr_data});
            if (wr_prev) wide_cnt <= wide_cnt + 1;
        end
        if (bus.done === 1'b1) begin
            done_cnt <= done_cnt + 1;
            if (bus.wr_en === 1'b1 && bus.wr_addr == 15'(LAST)) done_last <= done_last + 1;
        end
        wr_prev <= (bus.wr_en === 1'b1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic pclk_cycle(input logic href, input logic [7:0] d);
        @(negedge clk);
        bus.cam_pclk = 1'b0;
        bus.cam_href = href;
        bus.cam_data = d;
        repeat (3) @(negedge clk);
        bus.cam_pclk = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    // One camera frame: VSYNC pulse, then lines of random bytes, ending with VSYNC high
    task automatic send_frame(input int lines, input int cols);
        bus.cam_vsync = 1'b1;
        repeat (4) pclk_cycle(1'b0, 8'h00);
        bus.cam_vsync = 1'b0;
        repeat (4) pclk_cycle(1'b0, 8'h00);
        for (int l = 0; l < lines; l++) begin
            for (int c = 0; c < cols; c++) begin
                src[l][c] = 8'($urandom);
                pclk_cycle(1'b1, src[l][c]);
            end
            repeat (3) pclk_cycle(1'b0, 8'h00);
        end
        bus.cam_vsync = 1'b1;
        repeat (4) pclk_cycle(1'b0, 8'h00);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    // Stored byte k comes from source line DEC_Y*(k/IMG_W), column DEC_X*(k%IMG_W)
    task automatic check_capture(input string tag, input int b, input int db, input int dl,
                                 input int exp_n, input logic exp_short, input int exp_last);
        chk({tag, ".writes"}, wq.size() - b, exp_n);
        for (int k = 0; k < exp_n && b + k < wq.size(); k++)
            chk({tag, ".byte"}, 32'(wq[b + k]),
                32'({15'(k), src[DEC_Y * (k / IMG_W)][DEC_X * (k % IMG_W)]}));
        chk({tag, ".done"}, done_cnt - db, 1);
        chk({tag, ".done_with_last"}, done_last - dl, exp_last);
        chk({tag, ".short_frame"}, bus.short_frame, exp_short);
        chk({tag, ".busy"}, bus.busy, 0);
    endtask

    initial begin
        int b, db, dl, lines, cols, t;
        rst           = 1'b1;
        bus.start     = 1'b0;
        bus.cam_pclk  = 1'b0;
        bus.cam_vsync = 1'b0;
        bus.cam_href  = 1'b0;
        bus.cam_data  = 8'h00;

        // Reset held while the camera toggles
        for (int i = 0; i < 8; i++) begin
            bus.cam_vsync = logic'(i[1]);
            pclk_cycle(logic'(i[0]), 8'($urandom));
        end
        chk("reset.wr_addr", bus.wr_addr, 0);
        chk("reset.wr_data", bus.wr_data, 0);
        chk("reset.wr_en", bus.wr_en, 0);
        chk("reset.busy", bus.busy, 0);
        chk("reset.done", bus.done, 0);
        chk("reset.short_frame", bus.short_frame, 0);
        chk("reset.writes", wq.size(), 0);
        rst = 1'b0;

        // A full frame with no start produces nothing
        send_frame(12, 16);
        chk("nostart.writes", wq.size(), 0);
        chk("nostart.done", done_cnt, 0);
        chk("nostart.busy", bus.busy, 0);

        // Full frame, plus a start in the done cycle that must be ignored
        lines = $urandom_range(16, 11);
        cols  = $urandom_range(24, 15);
        b = wq.size(); db = done_cnt; dl = done_last;
        pulse_start();
        chk("full.busy_after_start", bus.busy, 1);
        fork
            send_frame(lines, cols);
            begin
                t = 0;
                while (bus.done !== 1'b1 && t < 8000) begin
                    @(negedge clk);
                    t++;
                end
                chk("full.done_seen", 32'(t < 8000), 1);
                bus.start = 1'b1;
                @(negedge clk);
                bus.start = 1'b0;
                chk("full.start_in_done_cycle", bus.busy, 0);
            end
        join
        repeat (4) @(negedge clk);
        check_capture("full", b, db, dl, NPIX, 1'b0, 1);

        // Start while a frame is in progress: capture only the following frame
        lines = $urandom_range(16, 11);
        cols  = $urandom_range(24, 15);
        b = wq.size(); db = done_cnt; dl = done_last;
        fork
            begin
                send_frame(12, 16);
                send_frame(lines, cols);
            end
            begin
                repeat (400) @(negedge clk);
                bus.start = 1'b1;
                @(negedge clk);
                bus.start = 1'b0;
            end
        join
        repeat (4) @(negedge clk);
        check_capture("midframe", b, db, dl, NPIX, 1'b0, 1);

        // Reset after 20 writes aborts; then a fresh full capture from address 0
        b = wq.size(); db = done_cnt;
        pulse_start();
        fork
            send_frame(12, 16);
            begin
                t = 0;
                while (wq.size() - b < 20 && t < 8000) begin
                    @(negedge clk);
                    t++;
                end
                chk("abort.reached_20", 32'(t < 8000), 1);
                rst = 1'b1;
                @(negedge clk);
                chk("abort.wr_en", bus.wr_en, 0);
                chk("abort.busy", bus.busy, 0);
                rst = 1'b0;
            end
        join
        repeat (4) @(negedge clk);
        chk("abort.writes", wq.size() - b, 20);
        chk("abort.no_done", done_cnt - db, 0);
        lines = $urandom_range(16, 11);
        cols  = $urandom_range(24, 15);
        b = wq.size(); db = done_cnt; dl = done_last;
        pulse_start();
        send_frame(lines, cols);
        repeat (4) @(negedge clk);
        check_capture("after_abort", b, db, dl, NPIX, 1'b0, 1);

        // Short frame: 5 lines keep lines 0, 2, 4 -> 3 stored lines
        cols = $urandom_range(24, 15);
        b = wq.size(); db = done_cnt; dl = done_last;
        pulse_start();
        send_frame(5, cols);
        repeat (4) @(negedge clk);
        check_capture("short", b, db, dl, 3 * IMG_W, 1'b1, 0);
        pulse_start();
        chk("short.cleared_by_start", bus.short_frame, 0);
        chk("short.busy_after_start", bus.busy, 1);
        lines = $urandom_range(16, 11);
        cols  = $urandom_range(24, 15);
        b = wq.size(); db = done_cnt; dl = done_last;
        send_frame(lines, cols);
        repeat (4) @(negedge clk);
        check_capture("after_short", b, db, dl, NPIX, 1'b0, 1);

        // Overlong lines and frame: extra bytes and lines dropped
        b = wq.size(); db = done_cnt; dl = done_last;
        pulse_start();
        send_frame(20, 24);
        repeat (4) @(negedge clk);
        check_capture("overlong", b, db, dl, NPIX, 1'b0, 1);

        chk("wr_en_single_cycle", wide_cnt, 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
